// File: rtl/init_pkg.sv
// Shared state encoding for the RC4 FSMs: S-array init, key schedule and top level.
// Also holds the memory geometry that these FSMs share.
package init_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01
  } state_t;

endpackage

// File: rtl/init_if.sv
// Start/ready handshake plus the memory write port of the S-array init block.
// The master side (init) drives rdy and the write port; the slave side drives en.
interface init_if;
  import init_pkg::*;

  logic              en;
  logic              rdy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic              wren;

  modport master (input en, output rdy, addr, wrdata, wren);
  modport slave  (output en, input rdy, addr, wrdata, wren);

endinterface

// File: rtl/init.sv
// Fills a 256x8 memory with mem[i]=i: 256 back-to-back writes, then rdy returns the next cycle.
// en is only taken while idle; the memory port has no backpressure. Outputs are Moore-decoded.
module init
  import init_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  init_if.master  bus
);

  state_t            present_state;
  state_t            next_state;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] next_counter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      present_state <= IDLE;
      counter       <= '0;
    end else begin
      present_state <= next_state;
      counter       <= next_counter;
    end
  end

  always_comb begin
    next_state   = present_state;
    next_counter = counter;
    bus.rdy      = 1'b0;
    bus.wren     = 1'b0;
    bus.addr     = '0;
    bus.wrdata   = '0;
    case (present_state)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) begin
          next_state   = WRITE;
          next_counter = '0;
        end
      end
      WRITE: begin
        bus.wren   = 1'b1;
        bus.addr   = counter;
        bus.wrdata = counter;
        // The last address ends the pass; the counter must not wrap into a second sweep.
        if (counter == 8'd255) begin
          next_state   = IDLE;
          next_counter = '0;
        end else begin
          next_counter = counter + 8'd1;
        end
      end
      default: begin
        next_state   = IDLE;
        next_counter = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_init.sv
// Directed bench for init: reset, full sweeps, en activity during a sweep, async abort.
module tb_init;
  import init_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   check_cnt = 0;

  init_if bus();

  init dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic expect_io(input string tag, input logic [1:0] st, input logic r,
                           input logic w, input logic [7:0] a);
    chk({tag, ".state"}, 32'(dut.present_state), 32'(st));
    chk({tag, ".out"}, {14'b0, bus.rdy, bus.wren, bus.addr, bus.wrdata},
        {14'b0, r, w, a, a});
  endtask

  initial begin
    rst    = 1'b1;
    bus.en = 1'b0;

    @(posedge clk);
    @(negedge clk);
    expect_io("reset", IDLE, 1'b1, 1'b0, 8'd0);
    rst = 1'b0;

    // Idle without en must hold.
    repeat (3) @(negedge clk);
    expect_io("idle_hold", IDLE, 1'b1, 1'b0, 8'd0);

    // Pass 1: single-cycle en, plain sweep.
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    expect_io("start", WRITE, 1'b0, 1'b1, 8'd0);
    for (int k = 0; k < 256; k++) begin
      expect_io($sformatf("sweep%0d", k), WRITE, 1'b0, 1'b1, 8'(k));
      @(negedge clk);
    end
    expect_io("done1", IDLE, 1'b1, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    expect_io("done1_hold", IDLE, 1'b1, 1'b0, 8'd0);

    // Pass 2: en toggles every cycle during the sweep.
    bus.en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      bus.en = ~bus.en;
      expect_io($sformatf("tog%0d", k), WRITE, 1'b0, 1'b1, 8'(k));
      @(negedge clk);
    end
    bus.en = 1'b0;
    expect_io("done2", IDLE, 1'b1, 1'b0, 8'd0);

    // Pass 3: en held high across a completion restarts after one idle cycle.
    bus.en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      expect_io($sformatf("held%0d", k), WRITE, 1'b0, 1'b1, 8'(k));
      @(negedge clk);
    end
    expect_io("done3", IDLE, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    expect_io("restart", WRITE, 1'b0, 1'b1, 8'd0);
    for (int k = 0; k < 100; k++) @(negedge clk);
    bus.en = 1'b0;
    expect_io("pre_abort", WRITE, 1'b0, 1'b1, 8'd100);

    // Reset mid-sweep takes effect without a clock edge.
    rst = 1'b1;
    #1;
    expect_io("abort_async", IDLE, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      expect_io($sformatf("post_abort%0d", k), IDLE, 1'b1, 1'b0, 8'd0);
    end

    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    expect_io("after_abort_start", WRITE, 1'b0, 1'b1, 8'd0);
    @(negedge clk);
    expect_io("after_abort_next", WRITE, 1'b0, 1'b1, 8'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
